systolic_drain: RTL and testbench

Result-collection block for the 2x2 systolic matrix-multiply array; the consuming end of the control unit's drain protocol. It watches the control unit's phase code `v` and tile coordinates `x`/`y`, and captures the four PE accumulators in the cycles the control unit clears them. It holds each completed tile in a ping-pong buffer and streams the results out one per cycle over a valid/ready handshake, tagged with row/column. It sits between the array (PE accumulators, control-unit outputs) and the result sink (memory writer or host port).

---
 rtl/systolic_pkg.sv | 21 ++
 rtl/systolic_drain_if.sv | 22 ++
 rtl/systolic_tile_bank.sv | 106 ++++++++++
 rtl/systolic_drain.sv | 127 ++++++++++++
 tb/tb_systolic_drain.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/systolic_pkg.sv
// systolic_pkg: shared constants for the 2x2 systolic array result path.
//   DATA_SIZE / AXIS_NUM / ACC_W : operand, tile-coordinate and accumulator widths
//   V_*                          : drain phase codes driven by the control unit
//   BANK_*                       : ping-pong bank state encoding
package systolic_pkg;

  localparam int DATA_SIZE = 8;
  localparam int AXIS_NUM  = 3;
  // Two 8x8 products summed need one extra bit beyond 2*DATA_SIZE.
  localparam int ACC_W     = 2 * DATA_SIZE + 1;

  localparam logic [1:0] V_IDLE = 2'd0;
  localparam logic [1:0] V_P1   = 2'd1;  // PE11 done, tile coordinates valid
  localparam logic [1:0] V_P2   = 2'd2;  // PE12 and PE21 done
  localparam logic [1:0] V_P3   = 2'd3;  // PE22 done, tile complete

  localparam logic [1:0] BANK_EMPTY   = 2'd0;
  localparam logic [1:0] BANK_FILLING = 2'd1;
  localparam logic [1:0] BANK_FULL    = 2'd2;

endpackage

// File: rtl/systolic_drain_if.sv
// systolic_drain_if: result stream from the drain block to the result sink.
//   out_valid : out_data/out_row/out_col carry a result
//   out_ready : sink accepts the current result
//   out_data  : accumulator value, unmodified
//   out_row   : {tile x, local row bit}
//   out_col   : {tile y, local col bit}
// Handshake: a result transfers on every rising edge where out_valid and
// out_ready are both 1. Once out_valid is raised, it and the payload hold
// unchanged until that transfer; out_valid never depends on out_ready.
interface systolic_drain_if #(
  parameter int ACC_W    = systolic_pkg::ACC_W,
  parameter int AXIS_NUM = systolic_pkg::AXIS_NUM
);
  logic                out_valid;
  logic                out_ready;
  logic [ACC_W-1:0]    out_data;
  logic [AXIS_NUM:0]   out_row;
  logic [AXIS_NUM:0]   out_col;

  modport master (output out_valid, out_data, out_row, out_col, input out_ready);
  modport slave  (input out_valid, out_data, out_row, out_col, output out_ready);
endinterface

// File: rtl/systolic_tile_bank.sv
// systolic_tile_bank: one half of the ping-pong result buffer.
//   cap_p1/cap_p2/cap_p3 : capture strobes for phase 1/2/3 (only acted on in the right state)
//   x, y, c11..c22       : tile coordinates and PE accumulators
//   pop                  : current entry accepted by the sink
//   state_o              : registered bank state (EMPTY/FILLING/FULL)
//   state_next_o         : state after this edge
//   idx_next_o           : drain index after this edge
//   data_next_o          : entry selected by idx_next_o (lets the top register its outputs)
//   x_o, y_o             : latched tile coordinates
module systolic_tile_bank #(
  parameter int ACC_W    = systolic_pkg::ACC_W,
  parameter int AXIS_NUM = systolic_pkg::AXIS_NUM
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cap_p1,
  input  logic                cap_p2,
  input  logic                cap_p3,
  input  logic [AXIS_NUM-1:0] x,
  input  logic [AXIS_NUM-1:0] y,
  input  logic [ACC_W-1:0]    c11,
  input  logic [ACC_W-1:0]    c12,
  input  logic [ACC_W-1:0]    c21,
  input  logic [ACC_W-1:0]    c22,
  input  logic                pop,
  output logic [1:0]          state_o,
  output logic [1:0]          state_next_o,
  output logic [1:0]          idx_next_o,
  output logic [ACC_W-1:0]    data_next_o,
  output logic [AXIS_NUM-1:0] x_o,
  output logic [AXIS_NUM-1:0] y_o
);
  import systolic_pkg::*;

  logic [1:0]          state_q, state_d;
  logic [1:0]          idx_q, idx_d;
  logic [ACC_W-1:0]    entry_q [4];
  logic [ACC_W-1:0]    entry_d [4];
  logic [AXIS_NUM-1:0] x_q, x_d, y_q, y_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    entry_d = entry_q;
    x_d     = x_q;
    y_d     = y_q;
    case (state_q)
      BANK_EMPTY: begin
        if (cap_p1) begin
          entry_d[0] = c11;
          x_d        = x;
          y_d        = y;
          state_d    = BANK_FILLING;
        end
      end
      BANK_FILLING: begin
        if (cap_p2) begin
          entry_d[1] = c12;
          entry_d[2] = c21;
        end
        if (cap_p3) begin
          entry_d[3] = c22;
          idx_d      = 2'd0;
          state_d    = BANK_FULL;
        end
      end
      BANK_FULL: begin
        if (pop) begin
          if (idx_q == 2'd3) begin
            idx_d   = 2'd0;
            state_d = BANK_EMPTY;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      default: state_d = BANK_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= BANK_EMPTY;
      idx_q   <= 2'd0;
      x_q     <= '0;
      y_q     <= '0;
      for (int i = 0; i < 4; i++) entry_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      x_q     <= x_d;
      y_q     <= y_d;
      entry_q <= entry_d;
    end
  end

  // A FULL bank never captures, so entry_q[idx_d] is already settled whenever
  // the top uses it (at the completing edge idx_d is 0 and entry 0 is old).
  assign state_o      = state_q;
  assign state_next_o = state_d;
  assign idx_next_o   = idx_d;
  assign data_next_o  = entry_q[idx_d];
  assign x_o          = x_q;
  assign y_o          = y_q;

endmodule

// File: rtl/systolic_drain.sv
// systolic_drain: captures the 2x2 array's accumulators as the control unit
// drains them, buffers completed tiles in two banks, and streams the four
// results of each tile out in order, tagged with global row/column.
//   clk, reset      : clock, asynchronous active-high reset
//   v, x, y         : drain phase and tile coordinates from the control unit
//   c11..c22        : PE accumulators
//   out_if (master) : result stream (out_valid/out_ready/out_data/out_row/out_col)
//   busy            : at least one bank holds a tile (filling or full)
//   overflow        : sticky; a tile arrived with no free bank and was dropped
module systolic_drain #(
  parameter int DATA_SIZE = systolic_pkg::DATA_SIZE,
  parameter int AXIS_NUM  = systolic_pkg::AXIS_NUM,
  parameter int ACC_W     = 2 * DATA_SIZE + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          v,
  input  logic [AXIS_NUM-1:0] x,
  input  logic [AXIS_NUM-1:0] y,
  input  logic [ACC_W-1:0]    c11,
  input  logic [ACC_W-1:0]    c12,
  input  logic [ACC_W-1:0]    c21,
  input  logic [ACC_W-1:0]    c22,
  systolic_drain_if.master    out_if,
  output logic                busy,
  output logic                overflow
);
  import systolic_pkg::*;

  logic [1:0]          bank_state      [2];
  logic [1:0]          bank_state_next [2];
  logic [1:0]          bank_idx_next   [2];
  logic [ACC_W-1:0]    bank_data_next  [2];
  logic [AXIS_NUM-1:0] bank_x          [2];
  logic [AXIS_NUM-1:0] bank_y          [2];
  logic [1:0]          cap_p1, cap_p2, cap_p3, pop;

  logic wr_sel_q, wr_sel_d, rd_sel_q, rd_sel_d;
  logic dropped_q, dropped_d, overflow_q, overflow_d, busy_q, busy_d;
  logic out_valid_q, out_valid_d;
  logic [ACC_W-1:0]  out_data_q, out_data_d;
  logic [AXIS_NUM:0] out_row_q, out_row_d, out_col_q, out_col_d;
  logic p1_ok, p1_drop, p2_ok, p3_ok, handshake;

  for (genvar g = 0; g < 2; g++) begin : g_bank
    systolic_tile_bank #(.ACC_W(ACC_W), .AXIS_NUM(AXIS_NUM)) u_bank (
      .clk(clk), .reset(reset),
      .cap_p1(cap_p1[g]), .cap_p2(cap_p2[g]), .cap_p3(cap_p3[g]),
      .x(x), .y(y), .c11(c11), .c12(c12), .c21(c21), .c22(c22),
      .pop(pop[g]),
      .state_o(bank_state[g]), .state_next_o(bank_state_next[g]),
      .idx_next_o(bank_idx_next[g]), .data_next_o(bank_data_next[g]),
      .x_o(bank_x[g]), .y_o(bank_y[g])
    );
  end

  always_comb begin
    // Only the write bank can be FILLING, so checking it covers the
    // "no FILLING bank" case for out-of-order phases. Phases of a dropped
    // tile are ignored until its phase 3 closes it.
    p1_ok   = (v == V_P1) && (bank_state[wr_sel_q] == BANK_EMPTY);
    p1_drop = (v == V_P1) && !p1_ok;
    p2_ok   = (v == V_P2) && !dropped_q && (bank_state[wr_sel_q] == BANK_FILLING);
    p3_ok   = (v == V_P3) && !dropped_q && (bank_state[wr_sel_q] == BANK_FILLING);
    handshake = out_valid_q && out_if.out_ready;

    cap_p1 = {p1_ok && wr_sel_q, p1_ok && !wr_sel_q};
    cap_p2 = {p2_ok && wr_sel_q, p2_ok && !wr_sel_q};
    cap_p3 = {p3_ok && wr_sel_q, p3_ok && !wr_sel_q};
    pop    = {handshake && rd_sel_q, handshake && !rd_sel_q};

    wr_sel_d = wr_sel_q ^ p3_ok;
    rd_sel_d = rd_sel_q ^ ((bank_state[rd_sel_q] == BANK_FULL) &&
                           (bank_state_next[rd_sel_q] == BANK_EMPTY));

    dropped_d = dropped_q;
    if (v == V_P1)      dropped_d = p1_drop;
    else if (v == V_P3) dropped_d = 1'b0;
    overflow_d = overflow_q || p1_drop;

    busy_d = (bank_state_next[0] != BANK_EMPTY) || (bank_state_next[1] != BANK_EMPTY);

    // Outputs are loaded from the banks' next state so out_valid rises on
    // the same edge that completes a tile, yet still comes from a flop.
    out_valid_d = (bank_state_next[rd_sel_d] == BANK_FULL);
    out_data_d  = out_data_q;
    out_row_d   = out_row_q;
    out_col_d   = out_col_q;
    if (out_valid_d) begin
      out_data_d = bank_data_next[rd_sel_d];
      out_row_d  = {bank_x[rd_sel_d], bank_idx_next[rd_sel_d][1]};
      out_col_d  = {bank_y[rd_sel_d], bank_idx_next[rd_sel_d][0]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_sel_q    <= 1'b0;
      rd_sel_q    <= 1'b0;
      dropped_q   <= 1'b0;
      overflow_q  <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_row_q   <= '0;
      out_col_q   <= '0;
    end else begin
      wr_sel_q    <= wr_sel_d;
      rd_sel_q    <= rd_sel_d;
      dropped_q   <= dropped_d;
      overflow_q  <= overflow_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_row_q   <= out_row_d;
      out_col_q   <= out_col_d;
    end
  end

  assign out_if.out_valid = out_valid_q;
  assign out_if.out_data  = out_data_q;
  assign out_if.out_row   = out_row_q;
  assign out_if.out_col   = out_col_q;
  assign busy             = busy_q;
  assign overflow         = overflow_q;

endmodule

// File: tb/tb_systolic_drain.sv
// tb_systolic_drain: bench for systolic_drain.
`timescale 1ns/1ps
module tb_systolic_drain;
  import systolic_pkg::*;

  localparam int AW = AXIS_NUM;
  localparam int CW = ACC_W;
  localparam int RW = CW + 2 * (AW + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]    v;
  logic [AW-1:0] x, y;
  logic [CW-1:0] c11, c12, c21, c22;
  logic          busy, overflow;

  systolic_drain_if out_if ();

  systolic_drain dut (
    .clk(clk), .reset(reset), .v(v), .x(x), .y(y),
    .c11(c11), .c12(c12), .c21(c21), .c22(c22),
    .out_if(out_if), .busy(busy), .overflow(overflow)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Abstract view: a FIFO of expected results, a count of complete tiles
  // waiting to drain (at most two), and the tile currently being assembled.
  logic [RW-1:0] exp_q[$];
  int            m_full = 0;
  int            m_pops = 0;
  bit            m_filling = 0, m_dropped = 0, m_overflow = 0;
  logic [AW-1:0] m_x, m_y;
  logic [CW-1:0] m_c [4];

  always @(posedge clk) begin
    if (reset) begin
      exp_q.delete();
      m_full = 0; m_pops = 0;
      m_filling = 0; m_dropped = 0; m_overflow = 0;
    end else begin
      int  full_pre;
      bit  popped;
      full_pre = m_full;
      popped   = (m_full > 0) && out_if.out_ready;
      if (popped) begin
        void'(exp_q.pop_front());
        m_pops++;
        if (m_pops == 4) begin m_pops = 0; m_full--; end
      end
      case (v)
        2'd1: begin
          if (!m_filling && full_pre < 2) begin
            m_filling = 1; m_dropped = 0;
            m_x = x; m_y = y; m_c[0] = c11;
          end else begin
            m_overflow = 1; m_dropped = 1;
          end
        end
        2'd2: if (m_filling && !m_dropped) begin m_c[1] = c12; m_c[2] = c21; end
        2'd3: begin
          if (m_filling && !m_dropped) begin
            m_c[3] = c22;
            for (int k = 0; k < 4; k++) begin
              logic r, c;
              r = (k >= 2);
              c = (k % 2 == 1);
              exp_q.push_back({m_c[k], m_x, r, m_y, c});
            end
            m_full++;
            m_filling = 0;
          end
          m_dropped = 0;
        end
        default: ;
      endcase
    end
  end

  // ---------------- scoreboard: every negedge out of reset ----------------
  always @(negedge clk) begin
    if (!reset) begin
      logic [RW-1:0] h;
      check("valid", 32'(out_if.out_valid), 32'(m_full > 0));
      if (m_full > 0 && out_if.out_valid) begin
        h = exp_q[0];
        check("data", 32'(out_if.out_data), 32'(h[RW-1 -: CW]));
        check("row",  32'(out_if.out_row),  32'(h[2*(AW+1)-1 -: AW+1]));
        check("col",  32'(out_if.out_col),  32'(h[AW:0]));
      end
      check("busy",     32'(busy),     32'(m_filling || m_full > 0));
      check("overflow", 32'(overflow), 32'(m_overflow));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [1:0] vv, input logic [AW-1:0] xx, input logic [AW-1:0] yy,
                       input logic [CW-1:0] a, input logic [CW-1:0] b,
                       input logic [CW-1:0] c, input logic [CW-1:0] d, input logic rdy);
    v = vv; x = xx; y = yy;
    c11 = a; c12 = b; c21 = c; c22 = d;
    out_if.out_ready = rdy;
    @(posedge clk); #1;
  endtask

  task automatic idle(input logic rdy);
    drive(2'd0, '0, '0, '0, '0, '0, '0, rdy);
  endtask

  task automatic tile(input logic [AW-1:0] xx, input logic [AW-1:0] yy,
                      input logic [CW-1:0] a, input logic [CW-1:0] b,
                      input logic [CW-1:0] c, input logic [CW-1:0] d, input logic rdy);
    drive(2'd1, xx, yy, a, '0, '0, '0, rdy);
    drive(2'd2, '0, '0, '0, b, c, '0, rdy);
    drive(2'd3, '0, '0, '0, '0, '0, d, rdy);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"},    32'(out_if.out_valid), 0);
    check({tag, "_data"},     32'(out_if.out_data),  0);
    check({tag, "_row"},      32'(out_if.out_row),   0);
    check({tag, "_col"},      32'(out_if.out_col),   0);
    check({tag, "_busy"},     32'(busy),             0);
    check({tag, "_overflow"}, 32'(overflow),         0);
  endtask

  typedef struct {
    logic [1:0]    v;
    logic [AW-1:0] x, y;
    logic [CW-1:0] c11, c12, c21, c22;
    logic          rdy;
    logic          e_valid;
    logic [CW-1:0] e_data;
    logic [AW:0]   e_row, e_col;
    logic          e_busy;
  } vec_t;

  vec_t tbl [7];

  initial begin
    automatic logic [CW-1:0] maxv = 17'h1FFFF;
    int n;
    logic [AW-1:0] rx, ry;
    logic [CW-1:0] r0, r1, r2, r3;
    int gap;

    // Single tile at (2,5), expectations after each cycle's edge.
    tbl[0] = '{2'd1, 3'd2, 3'd5, 17'd10, 17'd0,  17'd0,  17'd0,  1'b1, 1'b0, 17'd0,  4'd0, 4'd0,  1'b1};
    tbl[1] = '{2'd2, 3'd0, 3'd0, 17'd0,  17'd20, 17'd30, 17'd0,  1'b1, 1'b0, 17'd0,  4'd0, 4'd0,  1'b1};
    tbl[2] = '{2'd3, 3'd0, 3'd0, 17'd0,  17'd0,  17'd0,  17'd40, 1'b1, 1'b1, 17'd10, 4'd4, 4'd10, 1'b1};
    tbl[3] = '{2'd0, 3'd0, 3'd0, 17'd0,  17'd0,  17'd0,  17'd0,  1'b1, 1'b1, 17'd20, 4'd4, 4'd11, 1'b1};
    tbl[4] = '{2'd0, 3'd0, 3'd0, 17'd0,  17'd0,  17'd0,  17'd0,  1'b1, 1'b1, 17'd30, 4'd5, 4'd10, 1'b1};
    tbl[5] = '{2'd0, 3'd0, 3'd0, 17'd0,  17'd0,  17'd0,  17'd0,  1'b1, 1'b1, 17'd40, 4'd5, 4'd11, 1'b1};
    tbl[6] = '{2'd0, 3'd0, 3'd0, 17'd0,  17'd0,  17'd0,  17'd0,  1'b1, 1'b0, 17'd0,  4'd0, 4'd0,  1'b0};

    v = 2'd0; x = '0; y = '0; c11 = '0; c12 = '0; c21 = '0; c22 = '0;
    out_if.out_ready = 1'b0;

    // Reset state.
    #12;
    check_all_zero("reset");
    @(posedge clk); #2 reset = 1'b0;

    // Out-of-order phases: no capture, no flag.
    drive(2'd2, 3'd1, 3'd1, 17'd5, 17'd6, 17'd7, 17'd8, 1'b1);
    drive(2'd3, 3'd1, 3'd1, 17'd5, 17'd6, 17'd7, 17'd8, 1'b1);
    idle(1'b1);
    check("ooo_valid", 32'(out_if.out_valid), 0);
    check("ooo_overflow", 32'(overflow), 0);
    check("ooo_busy", 32'(busy), 0);

    // Table-driven single tile.
    for (int i = 0; i < 7; i++) begin
      drive(tbl[i].v, tbl[i].x, tbl[i].y, tbl[i].c11, tbl[i].c12, tbl[i].c21, tbl[i].c22, tbl[i].rdy);
      @(negedge clk);
      check($sformatf("tbl%0d_valid", i), 32'(out_if.out_valid), 32'(tbl[i].e_valid));
      check($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
      if (tbl[i].e_valid) begin
        check($sformatf("tbl%0d_data", i), 32'(out_if.out_data), 32'(tbl[i].e_data));
        check($sformatf("tbl%0d_row", i),  32'(out_if.out_row),  32'(tbl[i].e_row));
        check($sformatf("tbl%0d_col", i),  32'(out_if.out_col),  32'(tbl[i].e_col));
      end
    end

    // Backpressure: stall three cycles while entry 1 is presented.
    tile(3'd2, 3'd5, 17'd10, 17'd20, 17'd30, 17'd40, 1'b1);
    idle(1'b1);
    for (int i = 0; i < 3; i++) begin
      idle(1'b0);
      @(negedge clk);
      check("bp_hold_valid", 32'(out_if.out_valid), 1);
      check("bp_hold_data", 32'(out_if.out_data), 20);
      check("bp_hold_col", 32'(out_if.out_col), 11);
    end
    idle(1'b1);
    @(negedge clk);
    check("bp_next_data", 32'(out_if.out_data), 30);
    repeat (4) idle(1'b1);

    // Two tiles fill both banks, third is dropped.
    tile(3'd1, 3'd3, 17'd101, 17'd102, 17'd103, 17'd104, 1'b0);
    tile(3'd6, 3'd0, 17'd201, 17'd202, 17'd203, 17'd204, 1'b0);
    drive(2'd1, 3'd7, 3'd7, 17'd301, '0, '0, '0, 1'b0);
    @(negedge clk);
    check("b2b_overflow", 32'(overflow), 1);
    drive(2'd2, '0, '0, '0, 17'd302, 17'd303, '0, 1'b0);
    drive(2'd3, '0, '0, '0, '0, '0, 17'd304, 1'b0);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_if.out_valid) n++;
      idle(1'b1);
    end
    check("b2b_count", 32'(n), 8);

    // Reset after the phase-2 capture, then a fresh tile.
    drive(2'd1, 3'd1, 3'd6, 17'd77, '0, '0, '0, 1'b1);
    drive(2'd2, '0, '0, '0, 17'd78, 17'd79, '0, 1'b1);
    reset = 1'b1;
    #1;
    check_all_zero("midreset");
    @(posedge clk); #2 reset = 1'b0;
    tile(3'd4, 3'd3, 17'd1000, 17'd2000, 17'd3000, 17'd4000, 1'b1);
    repeat (5) idle(1'b1);

    // Maximum accumulator values.
    tile(3'd7, 3'd7, maxv, maxv, maxv, maxv, 1'b1);
    @(negedge clk);
    check("max_data", 32'(out_if.out_data), 131071);
    check("max_row", 32'(out_if.out_row), 14);
    repeat (5) idle(1'b1);

    // Randomised tiles, gaps, stray phases and backpressure.
    for (int t = 0; t < 60; t++) begin
      rx = AW'($urandom_range(0, 7));
      ry = AW'($urandom_range(0, 7));
      r0 = CW'($urandom_range(0, 131071));
      r1 = CW'($urandom_range(0, 131071));
      r2 = CW'($urandom_range(0, 131071));
      r3 = CW'($urandom_range(0, 131071));
      drive(2'd1, rx, ry, r0, '0, '0, '0, 1'($urandom_range(0, 9) < 6));
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) idle(1'($urandom_range(0, 9) < 6));
      drive(2'd2, '0, '0, '0, r1, r2, '0, 1'($urandom_range(0, 9) < 6));
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) idle(1'($urandom_range(0, 9) < 6));
      drive(2'd3, '0, '0, '0, '0, '0, r3, 1'($urandom_range(0, 9) < 6));
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) idle(1'($urandom_range(0, 9) < 6));
      if ($urandom_range(0, 9) == 0)
        drive(2'($urandom_range(2, 3)), rx, ry, r3, r2, r1, r0, 1'($urandom_range(0, 9) < 6));
    end
    repeat (12) idle(1'b1);
    @(negedge clk);
    check("final_busy", 32'(busy), 0);
    check("final_valid", 32'(out_if.out_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Bound on the whole run.
  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
